dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, consecutive cycles a pending debug request may be refused before it is forced through (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  MEM-stage access request (load or store).
REQ-005 cpu_we  input  4  unshifted byte mask: 0000 load, 0001 sb, 0011 sh, 1111 sw.
REQ-006 cpu_addr  input  32  byte address; cpu_wdata  input  32  store data, right-aligned.
REQ-007 cpu_gnt  output  1  CPU owns the RAM port this cycle; cpu_stall  output  1  cpu_req & ~cpu_gnt.
REQ-008 cpu_rvalid  output  1  read data for the CPU's granted load of the previous cycle; cpu_rdata  output  32  raw word.
REQ-009 dbg_req, dbg_we[4], dbg_addr[32], dbg_wdata[32]  inputs  debug/DMA requester, same encoding as CPU.
REQ-010 dbg_gnt, dbg_rvalid  output  1; dbg_rdata  output  32  as CPU equivalents.
REQ-011 ram_we  output  4; ram_addr  output  30 (word address); ram_din  output  32; ram_dout  input  32 (synchronous read, 1-cycle latency).
REQ-012 misalign_err  output  1  registered one-cycle pulse on a refused misaligned access.

Function
REQ-013 Arbitration: at most one of cpu_gnt/dbg_gnt high per cycle; grants are combinational from current requests and state.
REQ-014 Default priority: CPU wins when both request.
REQ-015 Starvation counter: increments each cycle dbg_req is high and dbg_gnt is low; clears on dbg_gnt or when dbg_req is low; saturates at STARVE_MAX.
REQ-016 When counter equals STARVE_MAX and dbg_req is high, debug wins that cycle regardless of cpu_req; CPU sees cpu_stall=1.
REQ-017 Lone requester is granted the same cycle it requests; no requests gives ram_we=0000, ram_addr from CPU inputs.
REQ-018 ram_addr = winner addr[31:2].
REQ-019 Byte lanes: we=1111 -> ram_we=1111, ram_din=wdata; otherwise ram_we = we << addr[1:0], ram_din = wdata << (8*addr[1:0]).
REQ-020 Misaligned: sh with addr[0]=1, or sw with addr[1:0]!=00 -> grant still issued, ram_we forced 0000, misalign_err pulses next cycle.
REQ-021 Loads are never misaligned at this level (byte extraction is downstream).
REQ-022 Read return: a granted load (we=0000) records owner tag; next cycle the owner's rvalid=1; other rvalid=0.
REQ-023 cpu_rdata and dbg_rdata both equal ram_dout every cycle; only rvalid qualifies.
REQ-024 Back-to-back loads by alternating owners return in order, one per cycle, no bubble.
REQ-025 Stores produce no rvalid.

Reset
REQ-026 While rst=1: cpu_gnt=dbg_gnt=0, ram_we=0000, starvation counter 0, owner tag cleared, cpu_rvalid=dbg_rvalid=0, misalign_err=0.
REQ-027 A load granted in the cycle rst rises returns no rvalid; first grant possible in the first cycle after rst falls.

Structure
REQ-028 Shared package holds the byte-mask constants (LOAD, SB, SH, SW) and the owner-tag enum (NONE, CPU, DBG).
REQ-029 One sub-module, dmem_lane_align, implements REQ-019/REQ-020 combinationally; instantiated once on the winner's signals.

Verification
REQ-030 CPU sw 0xDEADBEEF at 0x100, no dbg -> same cycle ram_we=1111, ram_addr=0x40, cpu_stall=0.
REQ-031 CPU sb 0x000000AB at 0x103 -> ram_we=1000, ram_din=0xAB000000.
REQ-032 Both request continuously, STARVE_MAX=4 -> CPU granted cycles 0-3, dbg granted cycle 4, cpu_stall=1 only in cycle 4, pattern repeats.
REQ-033 CPU load at 0x200 cycle N, dbg load at 0x204 cycle N+1 -> cpu_rvalid at N+1, dbg_rvalid at N+2, each with its ram_dout word.
REQ-034 CPU sh at 0x101 -> ram_we=0000, cpu_gnt=1, misalign_err=1 next cycle only.
REQ-035 rst asserted mid-starvation (counter=3) -> after release, dbg needs 4 more refused cycles before forced grant.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - Byte-mask encodings used by both requesters (load, sb, sh, sw).
//   - Owner tag that records who issued the load now in flight.
//   - Helper that classifies a byte mask as a load.
package dmem_arbiter_pkg;

  localparam logic [3:0] WE_LOAD = 4'b0000;
  localparam logic [3:0] WE_SB   = 4'b0001;
  localparam logic [3:0] WE_SH   = 4'b0011;
  localparam logic [3:0] WE_SW   = 4'b1111;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  function automatic logic is_load(input logic [3:0] we);
    return we == WE_LOAD;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a single granted access.
// Ports:
//   en         in   1   an access is granted this cycle
//   we         in   4   unshifted byte mask (load/sb/sh/sw encoding)
//   addr_lo    in   2   byte offset within the word
//   wdata      in   32  right-aligned store data
//   lane_we    out  4   per-byte RAM write enable (0 when not granted or misaligned)
//   lane_din   out  32  store data shifted onto its byte lanes
//   misaligned out  1   halfword on an odd address or word on a non-zero offset
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  lane_we,
  output logic [31:0] lane_din,
  output logic        misaligned
);

  always_comb begin
    misaligned = en && (((we == WE_SH) && addr_lo[0]) ||
                        ((we == WE_SW) && (addr_lo != 2'b00)));

    if (we == WE_SW) begin
      lane_we  = we;
      lane_din = wdata;
    end else begin
      lane_we  = we << addr_lo;
      lane_din = wdata << {addr_lo, 3'b000};
    end

    // A misaligned store still consumes its grant but must not touch RAM.
    if (!en || misaligned) begin
      lane_we = 4'b0000;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous data RAM.
// The CPU normally wins; a debug/DMA requester refused STARVE_MAX cycles in
// a row is forced through for one cycle. Load data returns one cycle after
// the grant and is qualified by the owning side's rvalid.
//
// Handshake: a requester holds req (with we/addr/wdata stable) until it
// sees its gnt high in the same cycle; the access is accepted on the rising
// edge where req & gnt are both high. rvalid is a one-cycle qualifier on
// the shared read data and has no back-pressure.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cpu_req/we/addr/wdata            CPU access request
//   cpu_gnt, cpu_stall               CPU owns the port / CPU must hold
//   cpu_rvalid, cpu_rdata            CPU load return
//   dbg_req/we/addr/wdata            debug/DMA access request
//   dbg_gnt, dbg_rvalid, dbg_rdata   debug grant and load return
//   ram_we, ram_addr, ram_din        RAM write enables, word address, data
//   ram_dout                         RAM read data (1-cycle latency)
//   misalign_err                     pulse the cycle after a refused store
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic [3:0]  dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [3:0]  ram_we,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic        misalign_err
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic        force_dbg;
  logic        any_gnt;
  logic [3:0]  win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_misaligned;
  owner_t      owner_q;
  logic        misalign_q;

  // Arbitration. Reset blocks both grants so nothing reaches RAM.
  assign force_dbg = dbg_req && (starve_cnt == STARVE_LIM);
  assign cpu_gnt   = !rst && cpu_req && !force_dbg;
  assign dbg_gnt   = !rst && dbg_req && (force_dbg || !cpu_req);
  assign cpu_stall = cpu_req && !cpu_gnt;
  assign any_gnt   = cpu_gnt || dbg_gnt;

  // Winner mux; defaults to the CPU so an idle port shows the CPU address.
  always_comb begin
    if (dbg_gnt) begin
      win_we    = dbg_we;
      win_addr  = dbg_addr;
      win_wdata = dbg_wdata;
    end else begin
      win_we    = cpu_we;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
    end
  end

  assign ram_addr = win_addr[31:2];

  dmem_lane_align u_lane_align (
    .en         (any_gnt),
    .we         (win_we),
    .addr_lo    (win_addr[1:0]),
    .wdata      (win_wdata),
    .lane_we    (ram_we),
    .lane_din   (ram_din),
    .misaligned (win_misaligned)
  );

  // Starvation counter: counts consecutive refused debug cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!dbg_req || dbg_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Owner of the load whose data appears on ram_dout next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= win_misaligned;
      if (any_gnt && is_load(win_we)) begin
        owner_q <= dbg_gnt ? OWN_DBG : OWN_CPU;
      end else begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // Qualifiers are also masked by rst so the first reset cycle cannot
  // return data for a load issued just before reset.
  assign cpu_rvalid   = !rst && (owner_q == OWN_CPU);
  assign dbg_rvalid   = !rst && (owner_q == OWN_DBG);
  assign misalign_err = !rst && misalign_q;

  assign cpu_rdata = ram_dout;
  assign dbg_rdata = ram_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (STARVE_MAX = 4) with a behavioural
// synchronous RAM. The driver pushes the hand-computed response for each
// cycle into exp_q; a monitor on the falling edge pops and compares.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req;
  logic [3:0]  dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [3:0]  ram_we;
  logic [29:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic        misalign_err;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_gnt      (cpu_gnt),
    .cpu_stall    (cpu_stall),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .misalign_err (misalign_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural RAM ----------------
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    ram_dout <= mem[ram_addr[7:0]];
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_din[8*b +: 8];
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h80] = 32'h11112222;
    mem[8'h81] = 32'h33334444;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        cg;
    logic        dg;
    logic        st;
    logic [3:0]  we;
    logic [29:0] addr;
    logic        chk_din;
    logic [31:0] din;
    logic        crv;
    logic        drv;
    logic        merr;
    logic [31:0] rdata;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    assert_cnt = 0;
  int    fail_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic exp_cyc(input string nm, input logic cg, input logic dg, input logic st,
                         input logic [3:0] we, input logic [29:0] addr,
                         input logic chk_din, input logic [31:0] din,
                         input logic crv, input logic drv, input logic merr,
                         input logic [31:0] rdata);
    exp_t e;
    e.cg = cg; e.dg = dg; e.st = st; e.we = we; e.addr = addr;
    e.chk_din = chk_din; e.din = din; e.crv = crv; e.drv = drv;
    e.merr = merr; e.rdata = rdata;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  exp_t  mon_e;
  string mon_nm;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      chk({mon_nm, ".cpu_gnt"},      32'(cpu_gnt),      32'(mon_e.cg));
      chk({mon_nm, ".dbg_gnt"},      32'(dbg_gnt),      32'(mon_e.dg));
      chk({mon_nm, ".cpu_stall"},    32'(cpu_stall),    32'(mon_e.st));
      chk({mon_nm, ".ram_we"},       32'(ram_we),       32'(mon_e.we));
      chk({mon_nm, ".ram_addr"},     32'(ram_addr),     32'(mon_e.addr));
      chk({mon_nm, ".cpu_rvalid"},   32'(cpu_rvalid),   32'(mon_e.crv));
      chk({mon_nm, ".dbg_rvalid"},   32'(dbg_rvalid),   32'(mon_e.drv));
      chk({mon_nm, ".misalign_err"}, 32'(misalign_err), 32'(mon_e.merr));
      if (mon_e.chk_din) chk({mon_nm, ".ram_din"}, ram_din, mon_e.din);
      if (mon_e.crv) chk({mon_nm, ".cpu_rdata"}, cpu_rdata, mon_e.rdata);
      if (mon_e.drv) chk({mon_nm, ".dbg_rdata"}, dbg_rdata, mon_e.rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  task automatic idle();
    set_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    set_dbg(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic dw;
  int   drain;

  initial begin
    rst = 1'b1;
    idle();

    // Reset state
    tick(); exp_cyc("rst0", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,0,0, 32'h0);
    tick(); exp_cyc("rst1", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,0,0, 32'h0);

    // CPU stores and lane steering
    tick(); rst = 1'b0; set_cpu(1, 4'hF, 32'h100, 32'hDEADBEEF);
    exp_cyc("cpu_sw", 1,0,0, 4'hF, 30'h40, 1,32'hDEADBEEF, 0,0,0, 32'h0);
    tick(); set_cpu(1, 4'h1, 32'h103, 32'h000000AB);
    exp_cyc("cpu_sb", 1,0,0, 4'h8, 30'h40, 1,32'hAB000000, 0,0,0, 32'h0);
    tick(); set_cpu(1, 4'h3, 32'h101, 32'h00001234);
    exp_cyc("cpu_sh_mis", 1,0,0, 4'h0, 30'h40, 0,32'h0, 0,0,0, 32'h0);
    tick(); idle();
    exp_cyc("mis_pulse", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,0,1, 32'h0);
    tick();
    exp_cyc("mis_clear", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,0,0, 32'h0);
    tick(); set_cpu(1, 4'h3, 32'h102, 32'h00005678);
    exp_cyc("cpu_sh_hi", 1,0,0, 4'hC, 30'h40, 1,32'h56780000, 0,0,0, 32'h0);

    // Lone debug store
    tick(); idle(); set_dbg(1, 4'hF, 32'h1FC, 32'hCAFEF00D);
    exp_cyc("dbg_sw", 0,1,0, 4'hF, 30'h7F, 1,32'hCAFEF00D, 0,0,0, 32'h0);

    // Alternating-owner loads return in order
    tick(); idle(); set_cpu(1, 4'h0, 32'h200, 32'h0);
    exp_cyc("cpu_ld", 1,0,0, 4'h0, 30'h80, 0,32'h0, 0,0,0, 32'h0);
    tick(); idle(); set_dbg(1, 4'h0, 32'h204, 32'h0);
    exp_cyc("dbg_ld", 0,1,0, 4'h0, 30'h81, 0,32'h0, 1,0,0, 32'h11112222);
    tick(); idle();
    exp_cyc("dbg_ret", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,1,0, 32'h33334444);

    // Read back the word built by the sw/sb/sh sequence
    tick(); set_cpu(1, 4'h0, 32'h100, 32'h0);
    exp_cyc("cpu_rb", 1,0,0, 4'h0, 30'h40, 0,32'h0, 0,0,0, 32'h0);
    tick(); idle();
    exp_cyc("cpu_rb_ret", 0,0,0, 4'h0, 30'h0, 0,32'h0, 1,0,0, 32'h5678BEEF);

    // Debug misaligned word store
    tick(); set_dbg(1, 4'hF, 32'h102, 32'h1);
    exp_cyc("dbg_sw_mis", 0,1,0, 4'h0, 30'h40, 0,32'h0, 0,0,0, 32'h0);
    tick(); idle();
    exp_cyc("dbg_mis_pulse", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,0,1, 32'h0);

    // Continuous contention: CPU x4 then debug forced, repeating
    for (int k = 0; k < 10; k++) begin
      tick();
      set_cpu(1, 4'hF, 32'h300, 32'h11111111);
      set_dbg(1, 4'hF, 32'h400, 32'h22222222);
      dw = (k % 5 == 4);
      exp_cyc("starve", !dw, dw, dw, 4'hF, dw ? 30'h100 : 30'hC0,
              1, dw ? 32'h22222222 : 32'h11111111, 0,0,0, 32'h0);
    end

    // Build the counter up to 3, then reset while it is pending
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_cyc("pre_rst", 1,0,0, 4'hF, 30'hC0, 1,32'h11111111, 0,0,0, 32'h0);
    end
    tick(); rst = 1'b1;
    exp_cyc("rst_mid", 0,0,1, 4'h0, 30'hC0, 0,32'h0, 0,0,0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick(); rst = 1'b0;
      dw = (k == 4);
      exp_cyc("post_rst", !dw, dw, dw, 4'hF, dw ? 30'h100 : 30'hC0,
              1, dw ? 32'h22222222 : 32'h11111111, 0,0,0, 32'h0);
    end

    // Reset suppresses pending and in-reset load returns
    tick(); idle(); set_cpu(1, 4'h0, 32'h200, 32'h0);
    exp_cyc("ld_then_rst", 1,0,0, 4'h0, 30'h80, 0,32'h0, 0,0,0, 32'h0);
    tick(); rst = 1'b1; idle();
    exp_cyc("rst_kills_rv", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,0,0, 32'h0);
    tick(); set_cpu(1, 4'h0, 32'h200, 32'h0);
    exp_cyc("ld_in_rst", 0,0,1, 4'h0, 30'h80, 0,32'h0, 0,0,0, 32'h0);
    tick(); rst = 1'b0; idle();
    exp_cyc("post_rst_idle", 0,0,0, 4'h0, 30'h0, 0,32'h0, 0,0,0, 32'h0);
    tick(); set_cpu(1, 4'h0, 32'h204, 32'h0);
    exp_cyc("first_grant", 1,0,0, 4'h0, 30'h81, 0,32'h0, 0,0,0, 32'h0);
    tick(); idle();
    exp_cyc("first_ret", 0,0,0, 4'h0, 30'h0, 0,32'h0, 1,0,0, 32'h33334444);

    // Drain the scoreboard with a bounded wait
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      tick();
      drain++;
    end
    assert_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
